// File: rtl/param_btb_if.sv
// Fetch-side bundle of the branch target buffer: two lookup ports, the resolved-branch
// update channel and the flush request/busy pair.
interface param_btb_if;
  logic        stallreq;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_type;
  logic        flush;
  logic        busy;
  logic        hit0;
  logic        hit1;
  logic        pred_direct0;
  logic        pred_direct1;
  logic [31:0] pred_address0;
  logic [31:0] pred_address1;

  modport master (
    output stallreq, pc, pc_plus, upd_valid, upd_pc, upd_taken, upd_target, upd_type, flush,
    input  busy, hit0, hit1, pred_direct0, pred_direct1, pred_address0, pred_address1
  );

  modport slave (
    input  stallreq, pc, pc_plus, upd_valid, upd_pc, upd_taken, upd_target, upd_type, flush,
    output busy, hit0, hit1, pred_direct0, pred_direct1, pred_address0, pred_address1
  );
endinterface

// File: rtl/param_btb.sv
// Set-associative branch target buffer with two combinational lookup ports,
// round-robin replacement per set and a one-set-per-cycle flush sweep.
//
// state | meaning
// IDLE  | normal lookup/update operation
// FLUSH | clearing set fcnt each cycle, lookups miss, updates dropped
module param_btb #(
  parameter int SETS = 256,
  parameter int WAYS = 2
) (
  input logic      clk,
  input logic      reset,
  param_btb_if.slave btb
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] fcnt;
  logic             busy;

  logic [WAYS-1:0]  valid      [SETS];
  logic [WAY_W-1:0] rr         [SETS];
  logic [TAG_W-1:0] tag_mem    [SETS][WAYS];
  logic [31:0]      target_mem [SETS][WAYS];
  logic [1:0]       ctr_mem    [SETS][WAYS];
  logic             jump_mem   [SETS][WAYS];

  // Lookup ports
  logic [31:0]      lk_pc  [2];
  logic [IDX_W-1:0] lk_idx [2];
  logic [TAG_W-1:0] lk_tag [2];
  logic             lk_any [2];
  logic [WAY_W-1:0] lk_way [2];
  logic             hit    [2];
  logic             dir    [2];
  logic [31:0]      addr   [2];

  always_comb begin
    lk_pc[0] = btb.pc;
    lk_pc[1] = btb.pc_plus;
    for (int p = 0; p < 2; p++) begin
      lk_idx[p] = lk_pc[p][IDX_W+1:2];
      lk_tag[p] = lk_pc[p][31:IDX_W+2];
      lk_any[p] = 1'b0;
      lk_way[p] = '0;
      // Scan downward so the lowest-numbered matching way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (valid[lk_idx[p]][w] && (tag_mem[lk_idx[p]][w] == lk_tag[p])) begin
          lk_any[p] = 1'b1;
          lk_way[p] = WAY_W'(w);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit[p]  = !busy && lk_any[p];
      dir[p]  = hit[p] && ctr_mem[lk_idx[p]][lk_way[p]][1];
      addr[p] = dir[p] ? target_mem[lk_idx[p]][lk_way[p]] : lk_pc[p] + 32'd8;
    end
  end

  assign btb.hit0          = hit[0];
  assign btb.hit1          = hit[1];
  assign btb.pred_direct0  = dir[0];
  assign btb.pred_direct1  = dir[1];
  assign btb.pred_address0 = addr[0];
  assign btb.pred_address1 = addr[1];
  assign btb.busy          = busy;

  // Update channel
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [WAY_W-1:0] u_way;
  logic             u_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] alloc_way;
  logic [WAY_W-1:0] rr_inc;
  logic             upd_en;

  always_comb begin
    u_idx   = btb.upd_pc[IDX_W+1:2];
    u_tag   = btb.upd_pc[31:IDX_W+2];
    u_hit   = 1'b0;
    u_way   = '0;
    u_inv   = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[u_idx][w] && (tag_mem[u_idx][w] == u_tag)) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (!valid[u_idx][w]) begin
        u_inv   = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
    alloc_way = u_inv ? inv_way : rr[u_idx];
    rr_inc    = (WAYS == 1) ? '0 : rr[u_idx] + 1'b1;
    upd_en    = btb.upd_valid && !btb.stallreq && !busy && !btb.flush;
  end

  // Flush FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (btb.flush) state_nxt = FLUSH;
      FLUSH:   if (fcnt == IDX_W'(SETS - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == FLUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      fcnt <= busy ? fcnt + 1'b1 : '0;
      if (busy) begin
        valid[fcnt] <= '0;
        rr[fcnt]    <= '0;
      end else if (upd_en && !u_hit && btb.upd_taken) begin
        valid[u_idx][alloc_way] <= 1'b1;
        if (!u_inv) rr[u_idx] <= rr_inc;
      end
    end
  end

  // Entry payload is meaningful only under its valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (u_hit) begin
        if (btb.upd_type) begin
          ctr_mem[u_idx][u_way]    <= 2'b11;
          jump_mem[u_idx][u_way]   <= 1'b1;
          target_mem[u_idx][u_way] <= btb.upd_target;
        end else if (btb.upd_taken) begin
          if (ctr_mem[u_idx][u_way] != 2'b11) ctr_mem[u_idx][u_way] <= ctr_mem[u_idx][u_way] + 2'd1;
          target_mem[u_idx][u_way] <= btb.upd_target;
        end else if (ctr_mem[u_idx][u_way] != 2'b00) begin
          ctr_mem[u_idx][u_way] <= ctr_mem[u_idx][u_way] - 2'd1;
        end
      end else if (btb.upd_taken) begin
        tag_mem[u_idx][alloc_way]    <= u_tag;
        target_mem[u_idx][alloc_way] <= btb.upd_target;
        jump_mem[u_idx][alloc_way]   <= btb.upd_type;
        ctr_mem[u_idx][alloc_way]    <= btb.upd_type ? 2'b11 : 2'b10;
      end
    end
  end

  // Branch type is held for later predictor stages; byte offset of upd_pc is ignored.
  logic unused_bits;
  assign unused_bits = ^{btb.upd_pc[1:0], jump_mem[lk_idx[0]][lk_way[0]]};

endmodule
